// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM encoding,
// BCD digit limits, synchroniser depth and a two-digit BCD increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [7:0]  CS_LIM     = 8'h99;
  localparam logic [7:0]  SEC_LIM    = 8'h59;
  localparam int unsigned SYNC_DEPTH = 2;

  typedef struct packed {
    logic [7:0] mins;
    logic [7:0] secs;
    logic [7:0] cs;
  } bcd_time_t;

  // Returns {carry, next} for a two-digit BCD field that wraps to 00 after lim.
  function automatic logic [8:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] r;
    if (v == lim)
      r = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector that
// emits a single-cycle PULSE for each low-to-high transition of D.
module sync_edge
  import stopwatch_pkg::*;
(
  input  logic MCLK,
  input  logic RESET,
  input  logic D,
  output logic PULSE
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;
  logic                  pulse_q;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_DEPTH-2:0], D};
      prev_q  <= sync_q[SYNC_DEPTH-1];
      pulse_q <= sync_q[SYNC_DEPTH-1] & ~prev_q;
    end
  end

  assign PULSE = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear FSM around a BCD
// MM:SS.CC counter advanced by a synchronised 100 Hz tick.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       CLK2_IN,
  input  logic       BTN_SS,
  input  logic       BTN_LC,
  output logic [7:0] DISP_MIN,
  output logic [7:0] DISP_SEC,
  output logic [7:0] DISP_CS,
  output logic       RUNNING,
  output logic       LAP_FROZEN,
  output logic       OVF
);

  localparam logic [7:0] MIN_LIM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  logic tick, ss, lc;

  sync_edge u_sync_tick (.MCLK(MCLK), .RESET(RESET), .D(CLK2_IN), .PULSE(tick));
  sync_edge u_sync_ss   (.MCLK(MCLK), .RESET(RESET), .D(BTN_SS),  .PULSE(ss));
  sync_edge u_sync_lc   (.MCLK(MCLK), .RESET(RESET), .D(BTN_LC),  .PULSE(lc));

  state_e    state_q, state_d;
  bcd_time_t cnt_q, cnt_d;
  bcd_time_t snap_q, snap_d;
  bcd_time_t disp_q;
  logic      frozen_q, frozen_d;
  logic      ovf_q, ovf_d;
  logic      running_q;

  logic       cs_c, sec_c, min_c;
  logic [7:0] cs_n, sec_n, min_n;

  always_comb begin
    {cs_c,  cs_n}  = bcd2_inc(cnt_q.cs,   CS_LIM);
    {sec_c, sec_n} = bcd2_inc(cnt_q.secs, SEC_LIM);
    {min_c, min_n} = bcd2_inc(cnt_q.mins, MIN_LIM);

    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    frozen_d = frozen_q;
    ovf_d    = ovf_q;

    // Counting keys off the current state, so a tick that coincides with the
    // stop press still counts while one that coincides with a start does not.
    if (tick && state_q == RUN) begin
      cnt_d.cs = cs_n;
      if (cs_c) begin
        cnt_d.secs = sec_n;
        if (sec_c) begin
          cnt_d.mins = min_n;
          if (min_c) ovf_d = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (ss) state_d = RUN;
      end
      RUN: begin
        if (ss) begin
          state_d = PAUSE;
        end else if (lc) begin
          if (!frozen_q) begin
            snap_d   = cnt_q;
            frozen_d = 1'b1;
          end else begin
            frozen_d = 1'b0;
          end
        end
      end
      PAUSE: begin
        if (ss) begin
          state_d = RUN;
        end else if (lc) begin
          state_d  = IDLE;
          cnt_d    = '0;
          snap_d   = '0;
          frozen_d = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      frozen_q  <= 1'b0;
      ovf_q     <= 1'b0;
      disp_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      frozen_q  <= frozen_d;
      ovf_q     <= ovf_d;
      disp_q    <= frozen_d ? snap_d : cnt_d;
      running_q <= (state_d == RUN);
    end
  end

  assign DISP_MIN   = disp_q.mins;
  assign DISP_SEC   = disp_q.secs;
  assign DISP_CS    = disp_q.cs;
  assign RUNNING    = running_q;
  assign LAP_FROZEN = frozen_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a vector table of actions with
// expected display/flag state, checked through a scoreboard queue.
module tb_stopwatch_ctrl;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLK2_IN = 1'b0;
  logic       BTN_SS = 1'b0;
  logic       BTN_LC = 1'b0;
  logic [7:0] DISP_MIN, DISP_SEC, DISP_CS;
  logic       RUNNING, LAP_FROZEN, OVF;

  always #10 MCLK = ~MCLK;

  // One-minute wrap point keeps the overflow boundary reachable in a short run.
  stopwatch_ctrl #(.MAX_MIN(1)) dut (
    .MCLK(MCLK), .RESET(RESET), .CLK2_IN(CLK2_IN), .BTN_SS(BTN_SS), .BTN_LC(BTN_LC),
    .DISP_MIN(DISP_MIN), .DISP_SEC(DISP_SEC), .DISP_CS(DISP_CS),
    .RUNNING(RUNNING), .LAP_FROZEN(LAP_FROZEN), .OVF(OVF)
  );

  typedef enum int {A_RESET, A_SS, A_LC, A_SSLC, A_SS_TICK, A_TICKS} act_e;

  typedef struct {
    act_e       act;
    int         n;
    logic [7:0] m, s, c;
    logic       r, f, o;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] m, s, c;
    logic       r, f, o;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      CLK2_IN = 1'b1; cyc(2);
      CLK2_IN = 1'b0; cyc(2);
    end
    cyc(4);
  endtask

  task automatic press(input logic ss, input logic lc, input logic tk);
    BTN_SS = ss; BTN_LC = lc; CLK2_IN = tk;
    cyc(2);
    BTN_SS = 1'b0; BTN_LC = 1'b0; CLK2_IN = 1'b0;
    cyc(6);
  endtask

  task automatic do_reset();
    RESET = 1'b1; cyc(1);
    RESET = 1'b0; cyc(2);
  endtask

  task automatic push_exp(input string name, input logic [7:0] m, s, c,
                          input logic r, f, o);
    exp_t e;
    e.name = name; e.m = m; e.s = s; e.c = c; e.r = r; e.f = f; e.o = o;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: DUT sampled with no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (DISP_MIN !== e.m || DISP_SEC !== e.s || DISP_CS !== e.c ||
        RUNNING !== e.r || LAP_FROZEN !== e.f || OVF !== e.o) begin
      n_miss++;
      $display("FAIL %s: got %h:%h.%h run=%b lap=%b ovf=%b, want %h:%h.%h run=%b lap=%b ovf=%b",
               e.name, DISP_MIN, DISP_SEC, DISP_CS, RUNNING, LAP_FROZEN, OVF,
               e.m, e.s, e.c, e.r, e.f, e.o);
    end
  endtask

  task automatic addv(input act_e a, input int n, input logic [7:0] m, s, c,
                      input logic r, f, o);
    vec_t v;
    v.act = a; v.n = n; v.m = m; v.s = s; v.c = c; v.r = r; v.f = f; v.o = o;
    vecs.push_back(v);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   action     n     min    sec    cs     run   lap   ovf
    addv(A_RESET,   0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_SS,      0,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   150,  8'h00, 8'h01, 8'h50, 1'b1, 1'b0, 1'b0);
    addv(A_SS,      0,    8'h00, 8'h01, 8'h50, 1'b0, 1'b0, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_SS,      0,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   37,   8'h00, 8'h00, 8'h37, 1'b1, 1'b0, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h37, 1'b1, 1'b1, 1'b0);
    addv(A_TICKS,   20,   8'h00, 8'h00, 8'h37, 1'b1, 1'b1, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h57, 1'b1, 1'b0, 1'b0);
    addv(A_RESET,   0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_SS,      0,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   9,    8'h00, 8'h00, 8'h09, 1'b1, 1'b0, 1'b0);
    addv(A_SS_TICK, 0,    8'h00, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
    addv(A_SS_TICK, 0,    8'h00, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0);
    addv(A_SSLC,    0,    8'h00, 8'h00, 8'h10, 1'b0, 1'b1, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_SS_TICK, 0,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   200,  8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_LC,      0,    8'h00, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0);
    addv(A_RESET,   0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_TICKS,   5,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    addv(A_SS,      0,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   5999, 8'h00, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   1,    8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   5999, 8'h01, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0);
    addv(A_TICKS,   1,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    addv(A_TICKS,   1,    8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
    addv(A_SS,      0,    8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    addv(A_LC,      0,    8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    cyc(3);
    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      push_exp($sformatf("vec%0d", k), v.m, v.s, v.c, v.r, v.f, v.o);
      case (v.act)
        A_RESET:   do_reset();
        A_SS:      press(1'b1, 1'b0, 1'b0);
        A_LC:      press(1'b0, 1'b1, 1'b0);
        A_SSLC:    press(1'b1, 1'b1, 1'b0);
        A_SS_TICK: press(1'b1, 1'b0, 1'b1);
        A_TICKS:   do_ticks(v.n);
        default:   ;
      endcase
      check_pop();
    end

    // Start button held across reset: the edge detector restarts at 0, so
    // exactly one start pulse follows release, and none on letting go.
    BTN_SS = 1'b1;
    push_exp("held_ss_after_reset", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    RESET = 1'b1; cyc(2);
    RESET = 1'b0; cyc(8);
    check_pop();
    push_exp("held_ss_single_pulse", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    BTN_SS = 1'b0; cyc(8);
    check_pop();

    // Count a little, then reset while tick and lap inputs rise together.
    push_exp("run_before_override", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    do_ticks(3);
    check_pop();
    push_exp("reset_overrides_inputs", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    CLK2_IN = 1'b1; BTN_LC = 1'b1;
    cyc(1);
    RESET = 1'b1; cyc(1);
    RESET = 1'b0; cyc(6);
    CLK2_IN = 1'b0; BTN_LC = 1'b0; cyc(6);
    check_pop();

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: MAX_MIN, default 59, highest minute value before wrap to 00.
REQ-002 MCLK  in  1  50 MHz system clock; all state updates on its rising edge.
REQ-003 RESET  in  1  reset; synchronous, active-high.
REQ-004 CLK2_IN  in  1  100 Hz square wave from the clock generator; level input, not used as a clock.
REQ-005 BTN_SS  in  1  start/stop button, level, asynchronous to MCLK.
REQ-006 BTN_LC  in  1  lap/clear button, level, asynchronous to MCLK.
REQ-007 DISP_MIN  out  8  BCD minutes {tens,units}.
REQ-008 DISP_SEC  out  8  BCD seconds {tens,units}.
REQ-009 DISP_CS  out  8  BCD centiseconds {tens,units}.
REQ-010 RUNNING  out  1  high while FSM is in RUN.
REQ-011 LAP_FROZEN  out  1  high while display shows the lap snapshot.
REQ-012 OVF  out  1  sticky flag, count wrapped past MAX_MIN:59.99.

Function
REQ-013 Each of CLK2_IN, BTN_SS, BTN_LC SHALL pass a 2-flop synchroniser, then a registered rising-edge detector giving a 1-MCLK pulse (tick, ss, lc).
REQ-014 Latency: a pulse SHALL assert 3 MCLK cycles after the first MCLK edge that samples its input high; counters and displays update 1 cycle after the tick pulse.
REQ-015 FSM states IDLE, RUN, PAUSE; reset state IDLE.
REQ-016 ss: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-017 lc in RUN: if LAP_FROZEN=0, copy live count into lap snapshot and set LAP_FROZEN; if LAP_FROZEN=1, clear LAP_FROZEN; counting continues in both cases.
REQ-018 lc in PAUSE: clear live count, snapshot, LAP_FROZEN and OVF to 0; go to IDLE.
REQ-019 lc in IDLE: no effect.
REQ-020 ss and lc in the same cycle: ss acts; lc is discarded.
REQ-021 Tick counts only when the state at that cycle is RUN; a tick coinciding with RUN->PAUSE counts; a tick coinciding with IDLE->RUN or PAUSE->RUN does not.
REQ-022 Counting is BCD: CS 00..99, carry into SEC 00..59, carry into MIN 00..MAX_MIN; no digit ever holds a value above 9.
REQ-023 At MAX_MIN:59.99 a tick SHALL wrap the count to 00:00.00, set OVF, and keep RUN.
REQ-024 DISP_* SHALL show the snapshot when LAP_FROZEN=1, otherwise the live count.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 RESET high at an MCLK edge SHALL force state IDLE, live count and snapshot to 00:00.00, all DISP_* to 8'h00, RUNNING/LAP_FROZEN/OVF to 0, and all synchroniser and edge-detect flops to 0.
REQ-027 RESET SHALL override any tick, ss or lc in the same cycle, including mid-run and while frozen.
REQ-028 After reset release, an input already high SHALL produce one pulse, since the edge-detect flop starts at 0.

Structure
REQ-029 Shared package stopwatch_pkg SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2), the BCD limits (CS 99, SEC 59) and the synchroniser depth (2).
REQ-030 The sub-module sync_edge (2-flop sync plus rising-edge pulse, ports MCLK, RESET, D, PULSE) SHALL be instantiated 3 times.
REQ-031 BCD counter and FSM logic SHALL stay in stopwatch_ctrl; target size 150-300 lines.

Verification
REQ-032 Reset; BTN_SS pulse; 150 CLK2_IN periods -> DISP = 00:01.50, RUNNING=1, OVF=0.
REQ-033 Running at 00:00.37: BTN_LC -> display frozen at 00:00.37, LAP_FROZEN=1; 20 ticks later live count = 00:00.57; second BTN_LC -> display shows 00:00.57, LAP_FROZEN=0.
REQ-034 Preload run to 00:59.99 and apply 1 tick -> 01:00.00; run to 59:59.99 and apply 1 tick -> 00:00.00, OVF=1, RUNNING=1.
REQ-035 BTN_SS and BTN_LC rising in the same cycle while in RUN -> PAUSE, LAP_FROZEN unchanged; then BTN_LC alone -> IDLE, all displays 00, OVF=0.
REQ-036 Tick pulse in the same cycle as the ss that stops RUN at 00:00.09 -> paused display 00:00.10.
REQ-037 RESET asserted for 1 cycle while RUN and frozen at 00:02.00 -> next cycle all outputs 0, state IDLE; further ticks do not count.
